// File: rtl/hiscore_pkg.sv
// rtl/hiscore_pkg.sv - shared state type and default timing constants for the hiscore RAM arbiter
package hiscore_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAUSE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_GRANT   = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_e;

    localparam int DEFAULT_SETTLE        = 4;
    localparam int DEFAULT_PAUSE_TIMEOUT = 255;
    localparam int CNT_W                 = 16;

endpackage

// File: rtl/hiscore_ram_arbiter.sv
// rtl/hiscore_ram_arbiter.sv - hands game RAM between the CPU and the hiscore engine
module hiscore_ram_arbiter
    import hiscore_pkg::*;
#(
    parameter int AW            = 10,
    parameter int SETTLE        = DEFAULT_SETTLE,
    parameter int PAUSE_TIMEOUT = DEFAULT_PAUSE_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_we,
    output logic [7:0]    cpu_din,
    input  logic          hs_access,
    input  logic          hs_write,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_dout,
    output logic          hs_grant,
    output logic [7:0]    hs_din,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    output logic [7:0]    dropped_writes
);

    arb_state_e       r_state;
    arb_state_e       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pause_req;
    logic             r_hs_grant;
    logic [7:0]       r_hs_din;
    logic [7:0]       r_dropped;
    logic             w_counting;

    // Losing hs_access always wins over pause_ack / timer expiry
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (hs_access) w_next_state = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (!hs_access)
                    w_next_state = ST_RELEASE;
                else if (pause_ack || r_cnt == CNT_W'(PAUSE_TIMEOUT - 1))
                    w_next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!hs_access)
                    w_next_state = ST_RELEASE;
                else if (r_cnt == CNT_W'(SETTLE - 1))
                    w_next_state = ST_GRANT;
            end
            ST_GRANT: begin
                if (!hs_access) w_next_state = ST_RELEASE;
            end
            ST_RELEASE: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // The shared counter runs only while PAUSE or SETTLE persists; any state change reloads it
    assign w_counting = (w_next_state == r_state) &&
                        (r_state == ST_PAUSE || r_state == ST_SETTLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pause_req <= 1'b0;
            r_hs_grant  <= 1'b0;
            r_hs_din    <= 8'h00;
            r_dropped   <= 8'h00;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_counting ? r_cnt + 1'b1 : '0;
            r_pause_req <= (w_next_state != ST_IDLE);
            r_hs_grant  <= (w_next_state == ST_GRANT);
            if (r_state == ST_GRANT)
                r_hs_din <= ram_dout;
            if (cpu_we && r_state != ST_IDLE && r_dropped != 8'hFF)
                r_dropped <= r_dropped + 8'd1;
        end
    end

    // PAUSE still presents the CPU address so the halting CPU sees stable reads
    always_comb begin
        ram_addr = hs_addr;
        ram_din  = hs_dout;
        ram_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ram_addr = cpu_addr;
                ram_din  = cpu_dout;
                ram_we   = cpu_we;
            end
            ST_PAUSE: begin
                ram_addr = cpu_addr;
                ram_din  = cpu_dout;
            end
            ST_GRANT: ram_we = hs_write;
            default: ;
        endcase
    end

    assign cpu_din        = ram_dout;
    assign hs_grant       = r_hs_grant;
    assign hs_din         = r_hs_din;
    assign pause_req      = r_pause_req;
    assign dropped_writes = r_dropped;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// tb/tb_hiscore_ram_arbiter.sv - self-checking bench for hiscore_ram_arbiter
module tb_hiscore_ram_arbiter;

    localparam int AW  = 10;
    localparam int STL = 4;
    localparam int PTO = 255;

    localparam int P_CPU      = 0;
    localparam int P_WAIT     = 1;
    localparam int P_SETTLE   = 2;
    localparam int P_OWN      = 3;
    localparam int P_HANDBACK = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_dout;
    logic          cpu_we;
    logic [7:0]    cpu_din;
    logic          hs_access;
    logic          hs_write;
    logic [AW-1:0] hs_addr;
    logic [7:0]    hs_dout;
    logic          hs_grant;
    logic [7:0]    hs_din;
    logic          pause_req;
    logic          pause_ack;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;
    logic [7:0]    dropped_writes;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem     [0:1023] = '{default: 8'h00};
    logic [7:0] exp_mem [0:1023] = '{default: 8'h00};

    always #5 clk = ~clk;

    hiscore_ram_arbiter #(.AW(AW), .SETTLE(STL), .PAUSE_TIMEOUT(PTO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_din(cpu_din),
        .hs_access(hs_access), .hs_write(hs_write), .hs_addr(hs_addr), .hs_dout(hs_dout),
        .hs_grant(hs_grant), .hs_din(hs_din),
        .pause_req(pause_req), .pause_ack(pause_ack),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .dropped_writes(dropped_writes)
    );

    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;
    assign ram_dout = mem[ram_addr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: ownership phases with entry timestamps, evaluated each negedge
    initial begin : model
        int            phase;
        int            wait_start;
        int            settle_start;
        int            cyc;
        logic [7:0]    e_dropped;
        logic [7:0]    e_hs_din;
        logic [AW-1:0] e_addr;
        logic [7:0]    e_din;
        logic          e_we;
        phase = P_CPU; wait_start = 0; settle_start = 0; cyc = 0;
        e_dropped = 8'h00; e_hs_din = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                phase = P_CPU; e_dropped = 8'h00; e_hs_din = 8'h00;
                check("rst_pause_req", 32'(pause_req), 32'(0));
                check("rst_hs_grant", 32'(hs_grant), 32'(0));
                check("rst_hs_din", 32'(hs_din), 32'(0));
                check("rst_dropped", 32'(dropped_writes), 32'(0));
                check("rst_ram_we", 32'(ram_we), 32'(cpu_we));
                check("rst_ram_addr", 32'(ram_addr), 32'(cpu_addr));
                if (cpu_we) exp_mem[cpu_addr] = cpu_dout;
            end else begin
                e_addr = hs_addr; e_din = hs_dout; e_we = 1'b0;
                if (phase == P_CPU) begin
                    e_addr = cpu_addr; e_din = cpu_dout; e_we = cpu_we;
                end else if (phase == P_WAIT) begin
                    e_addr = cpu_addr; e_din = cpu_dout;
                end else if (phase == P_OWN) begin
                    e_we = hs_write;
                end
                check("ram_addr", 32'(ram_addr), 32'(e_addr));
                check("ram_we", 32'(ram_we), 32'(e_we));
                if (e_we) check("ram_din", 32'(ram_din), 32'(e_din));
                check("cpu_din", 32'(cpu_din), 32'(exp_mem[e_addr]));
                check("pause_req", 32'(pause_req), 32'(phase != P_CPU));
                check("hs_grant", 32'(hs_grant), 32'(phase == P_OWN));
                check("hs_din", 32'(hs_din), 32'(e_hs_din));
                check("dropped_writes", 32'(dropped_writes), 32'(e_dropped));

                if (phase == P_OWN) e_hs_din = exp_mem[hs_addr];
                if (phase != P_CPU && cpu_we && e_dropped != 8'hFF) e_dropped = e_dropped + 8'd1;
                if (e_we) exp_mem[e_addr] = e_din;

                case (phase)
                    P_CPU: if (hs_access) begin phase = P_WAIT; wait_start = cyc + 1; end
                    P_WAIT: begin
                        if (!hs_access) phase = P_HANDBACK;
                        else if (pause_ack || (cyc + 1 - wait_start) >= PTO) begin
                            phase = P_SETTLE; settle_start = cyc + 1;
                        end
                    end
                    P_SETTLE: begin
                        if (!hs_access) phase = P_HANDBACK;
                        else if ((cyc + 1 - settle_start) >= STL) phase = P_OWN;
                    end
                    P_OWN: if (!hs_access) phase = P_HANDBACK;
                    default: phase = P_CPU;
                endcase
            end
            cyc++;
        end
    end

    initial begin : watchdog
        #400000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : stim
        int bad;
        reset_n = 1'b0; cpu_addr = '0; cpu_dout = 8'h00; cpu_we = 1'b0;
        hs_access = 1'b0; hs_write = 1'b0; hs_addr = '0; hs_dout = 8'h00; pause_ack = 1'b1;
        tick(); #3;
        check("reset_pause_req", 32'(pause_req), 32'(0));
        check("reset_dropped", 32'(dropped_writes), 32'(0));
        tick(); reset_n = 1'b1;
        tick(); tick();

        // Grant latency with ack tied high, and coincident CPU write
        tick(); hs_access = 1'b1; hs_addr = 10'h100; cpu_addr = 10'h011; cpu_dout = 8'hA7; cpu_we = 1'b1;
        #3 check("t0_cpu_write_passes", 32'(ram_we), 32'(1));
        tick(); cpu_we = 1'b0;
        #3 check("t1_pause_req", 32'(pause_req), 32'(1));
        check("t1_addr_cpu", 32'(ram_addr), 32'(10'h011));
        tick(); #3 check("t2_addr_hs", 32'(ram_addr), 32'(10'h100));
        tick(); tick(); tick(); #3 check("t5_no_grant", 32'(hs_grant), 32'(0));
        tick(); #3 check("t6_grant", 32'(hs_grant), 32'(1));
        check("coincident_write_kept", 32'(mem[10'h011]), 32'(8'hA7));

        // CPU writes while the engine owns RAM are discarded and counted
        cpu_addr = 10'h022; cpu_dout = 8'hEE;
        for (int i = 0; i < 300; i++) begin
            tick(); cpu_we = 1'b1; pause_ack = i[0];
            tick(); cpu_we = 1'b0;
        end
        pause_ack = 1'b1;
        tick(); #3 check("dropped_saturated", 32'(dropped_writes), 32'(255));
        check("dropped_ram_unchanged", 32'(mem[10'h022]), 32'(0));
        check("grant_held_ack_toggle", 32'(hs_grant), 32'(1));

        // Engine write then read-back
        tick(); hs_write = 1'b1; hs_addr = 10'h3A5; hs_dout = 8'h5C;
        tick(); hs_write = 1'b0;
        tick(); #3 check("hs_readback", 32'(hs_din), 32'(8'h5C));
        check("hs_write_landed", 32'(mem[10'h3A5]), 32'(8'h5C));

        // Re-request during RELEASE goes through exactly one IDLE cycle
        tick(); hs_access = 1'b0;
        tick(); hs_access = 1'b1;
        #3 check("release_pause_req", 32'(pause_req), 32'(1));
        check("release_no_grant", 32'(hs_grant), 32'(0));
        tick(); #3 check("idle_pause_req", 32'(pause_req), 32'(0));
        tick(); #3 check("repause_pause_req", 32'(pause_req), 32'(1));
        for (int i = 0; i < 5; i++) tick();
        #3 check("regrant", 32'(hs_grant), 32'(1));

        // Reset asserted mid-grant hands RAM straight back
        tick(); cpu_we = 1'b1; cpu_addr = 10'h033; cpu_dout = 8'h99; reset_n = 1'b0;
        #1 check("midrst_grant", 32'(hs_grant), 32'(0));
        check("midrst_pause_req", 32'(pause_req), 32'(0));
        check("midrst_ram_we", 32'(ram_we), 32'(1));
        check("midrst_ram_addr", 32'(ram_addr), 32'(10'h033));
        tick(); cpu_we = 1'b0; hs_access = 1'b0;
        tick(); reset_n = 1'b1;
        tick(); tick();

        // Pause timeout with no acknowledge
        tick(); pause_ack = 1'b0; hs_access = 1'b1; hs_addr = 10'h200; cpu_addr = 10'h044;
        for (int i = 1; i <= 255; i++) tick();
        #3 check("t255_still_paused", 32'(ram_addr), 32'(10'h044));
        tick(); #3 check("t256_settle_addr", 32'(ram_addr), 32'(10'h200));
        tick(); tick(); tick(); #3 check("t259_no_grant", 32'(hs_grant), 32'(0));
        tick(); #3 check("t260_grant", 32'(hs_grant), 32'(1));
        tick(); hs_access = 1'b0;
        tick(); tick();

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 39) == 0) hs_access = ~hs_access;
            hs_write  = 1'($urandom_range(0, 1));
            hs_addr   = AW'($urandom);
            hs_dout   = 8'($urandom);
            cpu_addr  = AW'($urandom);
            cpu_dout  = 8'($urandom);
            cpu_we    = 1'($urandom_range(0, 1));
            pause_ack = ($urandom_range(0, 3) == 0);
        end
        tick(); hs_access = 1'b0; cpu_we = 1'b0; hs_write = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #3;
        bad = 0;
        for (int a = 0; a < 1024; a++) if (mem[a] !== exp_mem[a]) bad++;
        check("ram_contents", 32'(bad), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hiscore_ram_arbiter.md
HISCORE_RAM_ARBITER -- requirements
Module: hiscore_ram_arbiter

Interface
REQ-001 The module SHALL have parameter AW, default 10, meaning the game RAM address width.
REQ-002 The module SHALL have parameter SETTLE, default 4, meaning the mux settle cycles before a grant (minimum 1).
REQ-003 The module SHALL have parameter PAUSE_TIMEOUT, default 255, meaning the maximum cycles to wait for pause_ack before proceeding.
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-005 The module SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_addr  in  AW  game CPU address.
- cpu_dout  in  8  game CPU write data.
- cpu_we  in  1  game CPU write strobe.
- cpu_din  out  8  RAM read data to the CPU; combinational passthrough of ram_dout.
- hs_access  in  1  hiscore engine access request (level).
- hs_write  in  1  hiscore engine write strobe.
- hs_addr  in  AW  hiscore engine address.
- hs_dout  in  8  hiscore engine write data.
- hs_grant  out  1  hiscore engine owns RAM.
- hs_din  out  8  registered RAM read data to the hiscore engine.
- pause_req  out  1  request for the core to halt its CPU.
- pause_ack  in  1  core CPU halted; tie to 1 if the core has no acknowledge.
- ram_addr  out  AW  muxed RAM address.
- ram_din  out  8  muxed RAM write data.
- ram_we  out  1  muxed RAM write enable.
- ram_dout  in  8  RAM read data.
- dropped_writes  out  8  saturating count of CPU writes discarded while the CPU was not the RAM owner.

Function
REQ-006 The state machine SHALL have five states: IDLE, PAUSE, SETTLE, GRANT, RELEASE; state and all outputs except the RAM mux and cpu_din SHALL be registered.
REQ-007 In IDLE, ram_addr/ram_din/ram_we SHALL equal cpu_addr/cpu_dout/cpu_we, and hs_access=1 SHALL move the state to PAUSE next cycle.
REQ-008 A cpu_we in the same cycle as the IDLE hs_access sample SHALL pass through to RAM unmodified.
REQ-009 In PAUSE, pause_req SHALL be 1; pause_ack=1 or the wait count reaching PAUSE_TIMEOUT SHALL move the state to SETTLE, with the wait counter reloaded to 0 on entry.
REQ-010 In SETTLE, the mux SHALL select hs_addr, ram_we SHALL be 0, and after exactly SETTLE cycles the state SHALL move to GRANT.
REQ-011 In GRANT, hs_grant SHALL be 1, the mux SHALL select hs_addr/hs_dout, and ram_we SHALL equal hs_write.
REQ-012 hs_din SHALL register ram_dout every GRANT cycle (1-cycle latency from hs_addr) and SHALL hold its last value outside GRANT.
REQ-013 hs_write outside GRANT SHALL be ignored.
REQ-014 hs_access=0 in PAUSE, SETTLE or GRANT SHALL move the state to RELEASE next cycle.
REQ-015 RELEASE SHALL last one cycle, keep the hs address mux with ram_we=0 and pause_req=1, then go to IDLE, where pause_req becomes 0.
REQ-016 A new hs_access during RELEASE SHALL be honoured only via IDLE, so at least one CPU-owned cycle occurs between grants.
REQ-017 With pause_ack tied 1 and SETTLE=4, hs_grant SHALL rise 6 cycles after the cycle in which IDLE sampled hs_access=1.
REQ-018 In any state other than IDLE, cpu_we=1 SHALL not reach RAM and SHALL increment dropped_writes, saturating at 255.
REQ-019 pause_ack dropping during SETTLE or GRANT SHALL have no effect; ownership is retained until hs_access falls.

Reset
REQ-020 reset_n low SHALL asynchronously force state=IDLE, pause_req=0, hs_grant=0, hs_din=0, dropped_writes=0 and the wait/settle counters to 0.
REQ-021 A reset asserted mid-GRANT SHALL return RAM ownership to the CPU immediately, with no write issued in the reset cycle.

Structure
REQ-022 A shared package hiscore_pkg SHALL hold the arbiter state enum and default constants for SETTLE and PAUSE_TIMEOUT.
REQ-023 The design SHALL be a single module with no sub-module; one counter SHALL be shared by the PAUSE and SETTLE states.

Verification
REQ-024 Bench: pause_ack=1, hs_access rises at t0 -> pause_req=1 at t1, hs_grant=1 at t6, ram_addr=hs_addr from t2.
REQ-025 Bench: pause_ack=0 permanently, PAUSE_TIMEOUT=255 -> SETTLE entered after 255 PAUSE cycles, then grant after 4 more cycles.
REQ-026 Bench: in GRANT, hs_write=1, hs_addr=0x3A5, hs_dout=0x5C -> RAM[0x3A5]=0x5C; a subsequent read of 0x3A5 gives hs_din=0x5C one cycle later.
REQ-027 Bench: 300 cpu_we pulses during GRANT -> RAM unchanged, dropped_writes=255; cpu_we coincident with the IDLE hs_access sample is written.
REQ-028 Bench: reset_n low mid-GRANT -> hs_grant=0, pause_req=0, ram_we=cpu_we immediately.
REQ-029 Bench: hs_access falls then rises again during RELEASE -> exactly one IDLE cycle with pause_req=0, then PAUSE.
